// File: rtl/bus_update_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bus_update_gen
//  Purpose  : Source-domain publisher for a bus clock-crossing receiver.
//             Each accepted value load appears on bus_src together with a
//             one-cycle bus_new_src pulse. Consecutive pulses are at least
//             HOLDOFF source clocks apart. Loads that arrive during holdoff
//             are coalesced into one pending value, and a saturating counter
//             records how many pending values were overwritten.
//  Options  : BUS_UPD_CHG_DET_EN - when defined, a load whose value equals
//             the current reference value (pend_val if a value is pending,
//             otherwise bus_src) is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_update_gen #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      HOLDOFF   = 8,   // legal range 2..256
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_src,
  input  logic             rst_clk_src_n,
  input  logic [WIDTH-1:0] val_in,
  input  logic             val_load,
  input  logic             coalesce_clr,
  output logic [WIDTH-1:0] bus_src,
  output logic             bus_new_src,
  output logic             busy,
  output logic [7:0]       coalesce_cnt
);

  // The holdoff counter only needs to hold HOLDOFF-1.
  localparam int unsigned      CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;

  localparam logic [7:0] c_coal_max = 8'hFF;

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [0:0]       state_q,    state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pend_q,     pend_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic [WIDTH-1:0] bus_q,      bus_d;
  logic             new_q,      new_d;
  logic             busy_q,     busy_d;
  logic [7:0]       coal_q,     coal_d;

  // Combinational helpers
  logic             w_load_acc;   // val_load that is actually accepted
  logic             w_cnt_zero;   // holdoff expires at this edge
  logic             w_coal_inc;   // a pending value is being overwritten

  assign w_cnt_zero = (hold_cnt_q == '0);

`ifdef BUS_UPD_CHG_DET_EN
  // Reference is what would be published next if nothing else arrived:
  // the pending value if there is one, otherwise what is already on the bus.
  logic [WIDTH-1:0] w_ref_val;
  assign w_ref_val  = pend_q ? pend_val_q : bus_q;
  assign w_load_acc = val_load && (val_in != w_ref_val);
`else
  assign w_load_acc = val_load;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_src) begin
    if (!rst_clk_src_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state: leave HOLD only when holdoff expires with nothing to send
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (w_load_acc) begin
          state_d = c_st_hold;
        end
      end
      c_st_hold: begin
        if (w_cnt_zero && !w_load_acc && !pend_q) begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs: publish, pending capture, holdoff count and coalesce count
  // --------------------------------------------------------------------------
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bus_d      = bus_q;
    new_d      = 1'b0;
    w_coal_inc = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (w_load_acc) begin
          bus_d      = val_in;
          new_d      = 1'b1;
          hold_cnt_d = c_reload;
        end
      end
      c_st_hold: begin
        if (!w_cnt_zero) begin
          hold_cnt_d = hold_cnt_q - c_one;
          if (w_load_acc) begin
            // Only an overwrite of an unpublished value counts as coalesced.
            w_coal_inc = pend_q;
            pend_d     = 1'b1;
            pend_val_d = val_in;
          end
        end else if (w_load_acc) begin
          // Newest value wins over the pending one; the pending value is
          // superseded at publication, not overwritten, so it is not counted.
          bus_d      = val_in;
          new_d      = 1'b1;
          hold_cnt_d = c_reload;
          pend_d     = 1'b0;
        end else if (pend_q) begin
          bus_d      = pend_val_q;
          new_d      = 1'b1;
          hold_cnt_d = c_reload;
          pend_d     = 1'b0;
        end
      end
      default: begin
        hold_cnt_d = '0;
        pend_d     = 1'b0;
      end
    endcase

    busy_d = (state_d == c_st_hold) | pend_d;

    // Clear wins over the old count but not over a same-cycle increment.
    if (coalesce_clr) begin
      coal_d = {7'd0, w_coal_inc};
    end else if (w_coal_inc && (coal_q != c_coal_max)) begin
      coal_d = coal_q + 8'd1;
    end else begin
      coal_d = coal_q;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers; reset discards any pending value without a pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_src) begin
    if (!rst_clk_src_n) begin
      hold_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bus_q      <= RESET_VAL;
      new_q      <= 1'b0;
      busy_q     <= 1'b0;
      coal_q     <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bus_q      <= bus_d;
      new_q      <= new_d;
      busy_q     <= busy_d;
      coal_q     <= coal_d;
    end
  end

  assign bus_src      = bus_q;
  assign bus_new_src  = new_q;
  assign busy         = busy_q;
  assign coalesce_cnt = coal_q;

endmodule
`default_nettype wire
